// File: rtl/muldiv_pkg.sv
// Shared opcode/state encodings for the iterative multiply/divide unit.
// Also imported by the controller and hazard logic.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } muldiv_state_t;

  // Signed ops take absolute values on entry and are sign-corrected in FIX.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_negcond.sv
// Conditional two's-complement negate: o_y = i_neg ? -i_x : i_x.
module negcond #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] i_x,
  input  logic         i_neg,
  output logic [N-1:0] o_y
);

  assign o_y = i_neg ? (~i_x + N'(1)) : i_x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with private HI/LO registers.
// Radix-2 shift-add multiply, restoring divide, one step per cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [2:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  muldiv_state_t    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;   // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0] r_m;     // multiplicand or divisor magnitude
  logic             r_sa;
  logic             r_sb;
  logic             r_is_mul;

  muldiv_op_t       w_op;
  logic             w_signed;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_mul_sum;
  logic [ACC_W-1:0] w_mul_next;
  logic [WIDTH:0]   w_div_sh;
  logic [WIDTH:0]   w_div_trial;
  logic             w_div_ok;
  logic [ACC_W-1:0] w_div_next;
  logic [ACC_W-1:0] w_res_in;
  logic [ACC_W-1:0] w_res;
  logic [WIDTH-1:0] w_rem;
  logic             w_last;

  assign w_op     = muldiv_op_t'(opE);
  assign w_signed = op_is_signed(opE);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  negcond #(.N(WIDTH)) u_abs_a (
    .i_x   (srcaE),
    .i_neg (w_signed & srcaE[WIDTH-1]),
    .o_y   (w_abs_a)
  );

  negcond #(.N(WIDTH)) u_abs_b (
    .i_x   (srcbE),
    .i_neg (w_signed & srcbE[WIDTH-1]),
    .o_y   (w_abs_b)
  );

  // Product or quotient correction shares one 2*WIDTH negator.
  negcond #(.N(ACC_W)) u_neg_res (
    .i_x   (w_res_in),
    .i_neg (r_sa ^ r_sb),
    .o_y   (w_res)
  );

  // Remainder follows the dividend sign.
  negcond #(.N(WIDTH)) u_neg_rem (
    .i_x   (r_acc[ACC_W-1:WIDTH]),
    .i_neg (r_sa),
    .o_y   (w_rem)
  );

  // One datapath step for each of multiply and divide.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[ACC_W-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
    w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
    w_div_sh    = {r_acc[ACC_W-1:WIDTH], r_acc[WIDTH-1]};
    w_div_trial = w_div_sh - {1'b0, r_m};
    w_div_ok    = ~w_div_trial[WIDTH];
    w_div_next  = {(w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_sh[WIDTH-1:0]),
                   r_acc[WIDTH-2:0], w_div_ok};
    w_res_in    = r_is_mul ? r_acc : {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]};
  end

  // Control FSM, iteration state and HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_m      <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_is_mul <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (startE) begin
            case (w_op)
              OP_MTHI: hi <= srcaE;
              OP_MTLO: lo <= srcaE;
              OP_MULT, OP_MULTU: begin
                r_acc    <= {{WIDTH{1'b0}}, w_abs_b};
                r_m      <= w_abs_a;
                r_sa     <= w_signed & srcaE[WIDTH-1];
                r_sb     <= w_signed & srcbE[WIDTH-1];
                r_is_mul <= 1'b1;
                r_cnt    <= '0;
                busy     <= 1'b1;
                r_state  <= ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
                r_m      <= w_abs_b;
                r_sa     <= w_signed & srcaE[WIDTH-1];
                r_sb     <= w_signed & srcbE[WIDTH-1];
                r_is_mul <= 1'b0;
                r_cnt    <= '0;
                busy     <= 1'b1;
                r_state  <= ST_DIV;
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_state <= ST_FIX;
        end
        ST_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_state <= ST_FIX;
        end
        ST_FIX: begin
          lo      <= w_res[WIDTH-1:0];
          hi      <= r_is_mul ? w_res[ACC_W-1:WIDTH] : w_rem;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32 and WIDTH=8 instances).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        startE = 1'b0;
  logic [2:0]  opE = 3'd0;
  logic [31:0] srcaE = '0, srcbE = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        startE8 = 1'b0;
  logic [2:0]  opE8 = 3'd0;
  logic [7:0]  srcaE8 = '0, srcbE8 = '0;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(rst_n), .startE(startE), .opE(opE),
    .srcaE(srcaE), .srcbE(srcbE), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst_n), .startE(startE8), .opE(opE8),
    .srcaE(srcaE8), .srcbE(srcbE8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one op at the next edge; return after busy drops (bounded), sampled #1 past edges.
  task automatic do_op32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cyc);
    @(negedge clk);
    opE = op; srcaE = a; srcbE = b; startE = 1'b1;
    @(posedge clk); #1;
    startE = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int cyc);
    @(negedge clk);
    opE8 = op; srcaE8 = a; srcbE8 = b; startE8 = 1'b1;
    @(posedge clk); #1;
    startE8 = 1'b0;
    cyc = 0;
    while (busy8 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{OP_MULTU, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006};
    vecs[6]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[10] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001};
    vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_hilo8", 64'({hi8, lo8}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven 32-bit ops: result, latency, single done pulse
    for (int i = 0; i < NV; i++) begin
      do_op32(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      chk($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].ehi));
      chk($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].elo));
      chk($sformatf("v%0d_busy_cycles", i), 64'(cyc), 64'd33);
      chk($sformatf("v%0d_done", i), 64'(done), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_drop", i), 64'(done), 64'd0);
    end

    // MTHI while busy is ignored
    @(negedge clk);
    opE = OP_DIVU; srcaE = 32'd100; srcbE = 32'd7; startE = 1'b1;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    opE = OP_MTHI; srcaE = 32'h1234; startE = 1'b1;
    @(negedge clk);
    startE = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("busy_mthi_hi", 64'(hi), 64'h2);
    chk("busy_mthi_lo", 64'(lo), 64'hE);

    // MTHI from idle: one edge, lo kept, busy never set
    do_op32(OP_MTHI, 32'h1234, 32'h0, cyc);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_lo", 64'(lo), 64'hE);
    chk("mthi_busy", 64'(cyc), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);
    do_op32(OP_MTLO, 32'h55, 32'h0, cyc);
    chk("mtlo_lo", 64'(lo), 64'h55);
    chk("mtlo_hi", 64'(hi), 64'h1234);

    // Undefined opcode is ignored
    do_op32(3'd6, 32'hDEAD, 32'hBEEF, cyc);
    chk("badop_busy", 64'(cyc), 64'd0);
    chk("badop_hilo", 64'({hi, lo}), {32'h1234, 32'h55});

    // Asynchronous reset mid-divide
    @(negedge clk);
    opE = OP_DIVU; srcaE = 32'd1000; srcbE = 32'd3; startE = 1'b1;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op32(OP_MULTU, 32'd2, 32'd3, cyc);
    chk("post_rst_lo", 64'(lo), 64'd6);
    chk("post_rst_hi", 64'(hi), 64'd0);
    chk("post_rst_cycles", 64'(cyc), 64'd33);

    // WIDTH=8 instance
    do_op8(OP_MULTU, 8'hFF, 8'hFF, cyc);
    chk("w8_mul_hi", 64'(hi8), 64'hFE);
    chk("w8_mul_lo", 64'(lo8), 64'h01);
    chk("w8_mul_cycles", 64'(cyc), 64'd9);
    chk("w8_mul_done", 64'(done8), 64'd1);
    do_op8(OP_DIV, 8'h80, 8'hFF, cyc);
    chk("w8_div_lo", 64'(lo8), 64'h80);
    chk("w8_div_hi", 64'(hi8), 64'h00);
    chk("w8_div_cycles", 64'(cyc), 64'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
